// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/stop and lap/clear buttons
// drive a four-state FSM and a 0.01 s tick divider.
module stopwatch_ctrl #(
   parameter int TICK_DIV   = 500000,
   parameter int QUICK_DIV  = 5000,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       lap_clr,
   input  logic       quick,
   output logic       tick,
   output logic       clr,
   output logic       hold,
   output logic [1:0] state
);

   localparam int MAXD = (TICK_DIV > QUICK_DIV) ? TICK_DIV : QUICK_DIV;
   localparam int W    = $clog2(MAXD + 1);
   localparam int DW   = $clog2(DEB_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } st_t;

   st_t st, st_n;

   // Bit 0 is start_stop, bit 1 is lap_clr.
   logic [1:0]    raw, s1, s2, deb, deb_q, ev;
   logic [DW-1:0] dcnt [2];
   logic [W-1:0]  div, lim;
   logic          act, act_n, wrap;

   assign raw = {lap_clr, start_stop};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= '0;
         s2    <= '0;
         deb   <= 2'b11;
         deb_q <= 2'b11;
         ev    <= '0;
         for (int i = 0; i < 2; i++) dcnt[i] <= '0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         deb_q <= deb;
         ev    <= deb & ~deb_q;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == deb[i]) begin
               dcnt[i] <= '0;
            end else if (dcnt[i] == DW'(DEB_CYCLES - 1)) begin
               deb[i]  <= s2[i];
               dcnt[i] <= '0;
            end else begin
               dcnt[i] <= dcnt[i] + 1'b1;
            end
         end
      end
   end

   // Start has priority; a simultaneous lap event is dropped.
   always_comb begin
      st_n = st;
      unique case (st)
         IDLE:  if (ev[0]) st_n = RUN;
         RUN:   if (ev[0]) st_n = PAUSE;
                else if (ev[1]) st_n = LAP;
         LAP:   if (ev[0]) st_n = PAUSE;
                else if (ev[1]) st_n = RUN;
         PAUSE: if (ev[0]) st_n = RUN;
                else if (ev[1]) st_n = IDLE;
      endcase
   end

   assign act   = (st == RUN) || (st == LAP);
   assign act_n = (st_n == RUN) || (st_n == LAP);
   assign lim   = quick ? W'(QUICK_DIV - 1) : W'(TICK_DIV - 1);
   // Only count across edges that stay in RUN/LAP, so a pause freezes
   // the phase and no tick lands in PAUSE or IDLE.
   assign wrap  = act && act_n && (div >= lim);

   always_ff @(posedge clk) begin
      if (rst) begin
         st   <= IDLE;
         div  <= '0;
         tick <= 1'b0;
         clr  <= 1'b0;
         hold <= 1'b0;
      end else begin
         st   <= st_n;
         tick <= wrap;
         clr  <= (st == PAUSE) && (st_n == IDLE);
         hold <= (st_n == LAP);
         if ((st == IDLE) || (st_n == IDLE))
            div <= '0;
         else if (act && act_n)
            div <= wrap ? '0 : div + 1'b1;
      end
   end

   assign state = st;

endmodule
